// File: rtl/pkg_99_4_7.sv
// Shared definitions for the MAC Merge verify block: state encodings, counter width
// and default verify-timer intervals.
package pkg_99_4_7;

    localparam int unsigned VERIFY_CNT_W = 3;

    localparam int unsigned VERIFY_TIME_SIM = 16;
    // 10 ms at a 125 MHz block clock.
    localparam int unsigned VERIFY_TIME_SILICON = 1_250_000;

    typedef enum logic [2:0] {
        StInitVerification = 3'd0,
        StVerificationIdle = 3'd1,
        StSendVerify       = 3'd2,
        StWaitForResponse  = 3'd3,
        StVerified         = 3'd4,
        StVerifyFail       = 3'd5
    } verify_state_e;

    function automatic logic is_timed_state(verify_state_e s);
        return (s == StVerificationIdle) || (s == StWaitForResponse);
    endfunction

    function automatic logic [VERIFY_CNT_W-1:0] sat_inc(logic [VERIFY_CNT_W-1:0] c);
        return (c == {VERIFY_CNT_W{1'b1}}) ? c : c + VERIFY_CNT_W'(1);
    endfunction

endpackage

// File: rtl/mod_99_4_7_verify_if.sv
// Verify/respond mPacket handshake and status bundle between the MAC Merge
// transmit/receive paths (master) and the verify block (slave).
interface mod_99_4_7_verify_if;
    import pkg_99_4_7::*;

    logic                    p_enable;
    logic                    disable_verify;
    logic                    link_fail;
    logic                    rcv_v;
    logic                    rcv_r;
    logic                    tx_v_ack;
    logic                    tx_r_ack;
    logic                    send_v;
    logic                    send_r;
    logic                    verified;
    logic                    verify_fail;
    logic [VERIFY_CNT_W-1:0] verify_cnt;
    logic                    preempt_active;
    logic [2:0]              state;

    modport master (
        output p_enable, disable_verify, link_fail, rcv_v, rcv_r, tx_v_ack, tx_r_ack,
        input  send_v, send_r, verified, verify_fail, verify_cnt, preempt_active, state
    );

    modport slave (
        input  p_enable, disable_verify, link_fail, rcv_v, rcv_r, tx_v_ack, tx_r_ack,
        output send_v, send_r, verified, verify_fail, verify_cnt, preempt_active, state
    );

endinterface

// File: rtl/mod_99_4_7_verify_timer.sv
// Verify-interval down-counter: start (re)loads VERIFY_TIME-1, done is high while the
// running count sits at zero, so an interval spans exactly VERIFY_TIME cycles.
module mod_99_4_7_verify_timer #(
    parameter int unsigned VERIFY_TIME = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic done
);

    localparam int unsigned CntW = $clog2(VERIFY_TIME);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            run_q, run_d;

    always_comb begin
        cnt_d = cnt_q;
        run_d = run_q;
        if (start) begin
            cnt_d = CntW'(VERIFY_TIME - 1);
            run_d = 1'b1;
        end else if (run_q) begin
            if (cnt_q == '0) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CntW'(1);
            end
        end
    end

    always_comb begin
        done = run_q && (cnt_q == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/mod_99_4_7_verify.sv
// MAC Merge verify state machine plus independent respond-mPacket handler; reports
// whether preemption may be used on the express/preemptable pair.
module mod_99_4_7_verify
    import pkg_99_4_7::*;
#(
    parameter int unsigned VERIFY_TIME  = VERIFY_TIME_SIM,
    parameter int unsigned VERIFY_LIMIT = 3
) (
    input logic                clk,
    input logic                reset,
    mod_99_4_7_verify_if.slave bus
);

    verify_state_e           state_q, state_d;
    logic                    send_v_q, send_v_d;
    logic                    send_r_q, send_r_d;
    logic                    verified_q, verified_d;
    logic                    verify_fail_q, verify_fail_d;
    logic [VERIFY_CNT_W-1:0] verify_cnt_q, verify_cnt_d;
    logic                    preempt_q, preempt_d;
    logic                    go_init;
    logic                    timer_start;
    logic                    timer_done;

    mod_99_4_7_verify_timer #(
        .VERIFY_TIME (VERIFY_TIME)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .start (timer_start),
        .done  (timer_done)
    );

    always_comb begin
        go_init       = bus.link_fail | bus.disable_verify | ~bus.p_enable;
        state_d       = state_q;
        send_v_d      = send_v_q;
        verified_d    = verified_q;
        verify_fail_d = verify_fail_q;
        verify_cnt_d  = verify_cnt_q;

        if (go_init) begin
            state_d       = StInitVerification;
            send_v_d      = 1'b0;
            verified_d    = 1'b0;
            verify_fail_d = 1'b0;
            verify_cnt_d  = '0;
        end else begin
            case (state_q)
                StInitVerification: state_d = StVerificationIdle;
                StVerificationIdle: begin
                    if (timer_done) begin
                        state_d      = StSendVerify;
                        send_v_d     = 1'b1;
                        verify_cnt_d = sat_inc(verify_cnt_q);
                    end
                end
                StSendVerify: begin
                    if (bus.tx_v_ack) begin
                        state_d  = StWaitForResponse;
                        send_v_d = 1'b0;
                    end
                end
                StWaitForResponse: begin
                    // A response landing on the expiry cycle still counts as success.
                    if (bus.rcv_r) begin
                        state_d    = StVerified;
                        verified_d = 1'b1;
                    end else if (timer_done) begin
                        if (verify_cnt_q < VERIFY_CNT_W'(VERIFY_LIMIT)) begin
                            state_d      = StSendVerify;
                            send_v_d     = 1'b1;
                            verify_cnt_d = sat_inc(verify_cnt_q);
                        end else begin
                            state_d       = StVerifyFail;
                            verify_fail_d = 1'b1;
                        end
                    end
                end
                StVerified:   state_d = StVerified;
                StVerifyFail: state_d = StVerifyFail;
                default:      state_d = StInitVerification;
            endcase
        end

        // Timing states are only ever entered from a different state.
        timer_start = is_timed_state(state_d) && (state_d != state_q);
    end

    always_comb begin
        send_r_d = send_r_q;
        if (~bus.p_enable | bus.link_fail) begin
            send_r_d = 1'b0;
        end else if (bus.rcv_v) begin
            send_r_d = 1'b1;
        end else if (bus.tx_r_ack) begin
            send_r_d = 1'b0;
        end
        preempt_d = bus.p_enable & ~bus.link_fail & (bus.disable_verify | verified_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StInitVerification;
            send_v_q      <= 1'b0;
            send_r_q      <= 1'b0;
            verified_q    <= 1'b0;
            verify_fail_q <= 1'b0;
            verify_cnt_q  <= '0;
            preempt_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            send_v_q      <= send_v_d;
            send_r_q      <= send_r_d;
            verified_q    <= verified_d;
            verify_fail_q <= verify_fail_d;
            verify_cnt_q  <= verify_cnt_d;
            preempt_q     <= preempt_d;
        end
    end

    assign bus.send_v         = send_v_q;
    assign bus.send_r         = send_r_q;
    assign bus.verified       = verified_q;
    assign bus.verify_fail    = verify_fail_q;
    assign bus.verify_cnt     = verify_cnt_q;
    assign bus.preempt_active = preempt_q;
    assign bus.state          = state_q;

endmodule

// File: tb/tb_mod_99_4_7_verify.sv
// Bench for mod_99_4_7_verify: directed scenarios followed by random traffic, all
// checked against a deadline-based reference model.
module tb_mod_99_4_7_verify;

    localparam int unsigned VT    = 16;
    localparam int unsigned LIMIT = 3;

    localparam int PInit = 0, PIdle = 1, PSend = 2, PWait = 3, PVer = 4, PFail = 5;

    logic clk;
    logic reset;
    mod_99_4_7_verify_if bus ();

    mod_99_4_7_verify #(
        .VERIFY_TIME  (VT),
        .VERIFY_LIMIT (LIMIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Model: phase plus absolute cycle number at which the current window expires.
    int m_phase = PInit;
    int m_cnt = 0;
    int m_deadline = 0;
    bit m_send_v = 0, m_send_r = 0, m_verified = 0, m_failed = 0, m_preempt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic launch();
        m_phase  = PSend;
        m_send_v = 1;
        m_cnt    = (m_cnt < 7) ? m_cnt + 1 : 7;
    endtask

    task automatic model_step();
        bit glob;
        bit n_pre;
        if (reset) begin
            m_phase = PInit; m_cnt = 0; m_send_v = 0; m_send_r = 0;
            m_verified = 0; m_failed = 0; m_preempt = 0;
            return;
        end
        n_pre = bus.p_enable && !bus.link_fail && (bus.disable_verify || m_verified);
        if (!bus.p_enable || bus.link_fail) m_send_r = 0;
        else if (bus.rcv_v) m_send_r = 1;
        else if (bus.tx_r_ack) m_send_r = 0;
        glob = bus.link_fail || bus.disable_verify || !bus.p_enable;
        if (glob) begin
            m_phase = PInit; m_cnt = 0; m_send_v = 0; m_verified = 0; m_failed = 0;
        end else begin
            case (m_phase)
                PInit: begin m_phase = PIdle; m_deadline = cyc + VT; end
                PIdle: if (cyc == m_deadline) launch();
                PSend: if (bus.tx_v_ack) begin
                    m_send_v = 0; m_phase = PWait; m_deadline = cyc + VT;
                end
                PWait: begin
                    if (bus.rcv_r) begin
                        m_phase = PVer; m_verified = 1;
                    end else if (cyc == m_deadline) begin
                        if (m_cnt < LIMIT) launch();
                        else begin m_phase = PFail; m_failed = 1; end
                    end
                end
                default: ;
            endcase
        end
        m_preempt = n_pre;
    endtask

    function automatic logic [10:0] dut_vec();
        return {bus.state, bus.send_v, bus.send_r, bus.verified, bus.verify_fail,
                bus.verify_cnt, bus.preempt_active};
    endfunction

    function automatic logic [10:0] model_vec();
        return {3'(m_phase), m_send_v, m_send_r, m_verified, m_failed, 3'(m_cnt), m_preempt};
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        bus.rcv_v = 0; bus.rcv_r = 0; bus.tx_v_ack = 0; bus.tx_r_ack = 0;
        check("outputs_vs_model", dut_vec(), model_vec());
    endtask

    initial begin
        int  rises;
        int  high_cnt;
        bit  prev;
        bit  raced;
        bit  hit;

        reset = 1;
        bus.p_enable = 1; bus.disable_verify = 0; bus.link_fail = 0;
        bus.rcv_v = 0; bus.rcv_r = 0; bus.tx_v_ack = 0; bus.tx_r_ack = 0;
        tick(); tick();
        check("reset_all_zero", dut_vec(), 11'd0);

        // Happy path
        reset = 0;
        for (int i = 0; i < 16; i++) tick();
        check("send_v_low_at_16", bus.send_v, 0);
        tick();
        check("send_v_rise_at_17", bus.send_v, 1);
        check("state_send_verify", bus.state, 2);
        bus.tx_v_ack = 1; tick();
        check("state_wait", bus.state, 3);
        check("send_v_cleared_by_ack", bus.send_v, 0);
        for (int i = 0; i < 4; i++) tick();
        bus.rcv_r = 1; tick();
        check("happy_verified", bus.verified, 1);
        check("happy_cnt", bus.verify_cnt, 1);
        check("happy_preempt_lags", bus.preempt_active, 0);
        tick();
        check("happy_preempt", bus.preempt_active, 1);

        // No response: three timeouts then fail
        bus.p_enable = 0; tick();
        check("global_clears_state", bus.state, 0);
        check("global_clears_verified", bus.verified, 0);
        bus.p_enable = 1;
        rises = 0; prev = 0;
        for (int i = 0; i < 240; i++) begin
            bus.tx_v_ack = bus.send_v;
            tick();
            if (bus.send_v && !prev) rises++;
            prev = bus.send_v;
        end
        check("fail_flag", bus.verify_fail, 1);
        check("fail_cnt", bus.verify_cnt, 3);
        check("fail_state", bus.state, 5);
        check("fail_send_v_rises", rises, 3);

        // Same-cycle race on the second attempt
        bus.p_enable = 0; tick(); bus.p_enable = 1;
        raced = 0;
        for (int i = 0; i < 200 && !raced; i++) begin
            bus.tx_v_ack = bus.send_v;
            hit = (m_phase == PWait) && (m_cnt == 2) && (m_deadline == cyc);
            bus.rcv_r = hit;
            tick();
            raced = hit;
        end
        check("race_reached", raced, 1);
        check("race_state", bus.state, 4);
        check("race_verified", bus.verified, 1);
        check("race_cnt", bus.verify_cnt, 2);

        // Bypass
        bus.disable_verify = 1; tick();
        check("bypass_state", bus.state, 0);
        high_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.send_v) high_cnt++;
        end
        check("bypass_no_send_v", high_cnt, 0);
        check("bypass_preempt", bus.preempt_active, 1);
        bus.rcv_v = 1; tick();
        check("bypass_send_r_set", bus.send_r, 1);
        tick(); tick(); tick();
        check("bypass_send_r_held", bus.send_r, 1);
        bus.rcv_v = 1; bus.tx_r_ack = 1; tick();
        check("send_r_v_and_ack", bus.send_r, 1);
        bus.tx_r_ack = 1; tick();
        check("send_r_ack_clears", bus.send_r, 0);

        // Link drop while waiting for a response
        bus.disable_verify = 0;
        for (int i = 0; i < 60 && m_phase != PWait; i++) begin
            bus.tx_v_ack = bus.send_v;
            tick();
        end
        check("link_reached_wait", bus.state, 3);
        bus.rcv_v = 1; tick();
        bus.link_fail = 1; tick();
        bus.link_fail = 0;
        check("link_state", bus.state, 0);
        check("link_cnt", bus.verify_cnt, 0);
        check("link_send_v", bus.send_v, 0);
        check("link_send_r", bus.send_r, 0);
        for (int i = 0; i < 16; i++) tick();
        check("link_restart_low", bus.send_v, 0);
        tick();
        check("link_restart_send_v", bus.send_v, 1);

        // Reset mid-timer
        bus.p_enable = 0; tick(); bus.p_enable = 1;
        for (int i = 0; i < 8; i++) tick();
        check("midtimer_in_idle", bus.state, 1);
        reset = 1; tick(); reset = 0;
        check("midtimer_reset_zero", dut_vec(), 11'd0);
        for (int i = 0; i < 16; i++) tick();
        check("retime_low_at_16", bus.send_v, 0);
        tick();
        check("retime_send_v_17", bus.send_v, 1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            reset              = ($urandom_range(0, 499) == 0);
            bus.p_enable       = ($urandom_range(0, 299) != 0);
            bus.link_fail      = ($urandom_range(0, 299) == 0);
            bus.disable_verify = ($urandom_range(0, 399) == 0);
            bus.rcv_v          = ($urandom_range(0, 7) == 0);
            bus.rcv_r          = ($urandom_range(0, 29) == 0);
            bus.tx_v_ack       = m_send_v ? ($urandom_range(0, 3) == 0)
                                          : ($urandom_range(0, 15) == 0);
            bus.tx_r_ack       = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mod_99_4_7_verify.md
# mod_99_4_7_verify

Clause 99 (IEEE 802.3br MAC Merge) verify state machine with its verify-response handler. Sits directly downstream of the Clause 99 timer block. It consumes a verify-timer interval and drives the verify/respond mPacket requests toward the MAC Merge transmit path. It reports whether preemption may be used on the express/preemptable pair. The verify timer is a synthesizable cycle counter, sized by parameter; the simulation-only timer model is not instantiated here.

## Interface
- `VERIFY_TIME`, 16, verify_timer duration in clock cycles; must be ≥ 2. Program 8–12 ms equivalent in silicon.
- `VERIFY_LIMIT`, 3, maximum verify mPackets sent before failure; range 1..7.
- `clk`  in  1  single block clock.
- `reset`  in  1  synchronous, active-high; also acts as 802.3 `begin`.
- `p_enable`  in  1  preemption enabled by management (`pEnable`).
- `disable_verify`  in  1  `disableVerify`; verification bypassed.
- `link_fail`  in  1  link down.
- `rcv_v`  in  1  one-cycle pulse: verify mPacket received.
- `rcv_r`  in  1  one-cycle pulse: respond mPacket received.
- `tx_v_ack`  in  1  one-cycle pulse: requested verify mPacket transmitted.
- `tx_r_ack`  in  1  one-cycle pulse: requested respond mPacket transmitted.
- `send_v`  out  1  request to transmit a verify mPacket; held until `tx_v_ack`.
- `send_r`  out  1  request to transmit a respond mPacket; held until `tx_r_ack`.
- `verified`  out  1  verification succeeded.
- `verify_fail`  out  1  verification failed after `VERIFY_LIMIT` attempts.
- `verify_cnt`  out  3  verify mPackets sent since INIT.
- `preempt_active`  out  1  `p_enable & ~link_fail & (disable_verify | verified)`; registered.
- `state`  out  3  current state encoding, for status and debug.

## Operation
- The state register encodes INIT_VERIFICATION=0, VERIFICATION_IDLE=1, SEND_VERIFY=2, WAIT_FOR_RESPONSE=3, VERIFIED=4, VERIFY_FAIL=5.
- Global transition: if `link_fail | disable_verify | ~p_enable` is high in any state, the next state is INIT_VERIFICATION. This condition overrides every other transition.
- INIT_VERIFICATION:
  - `verify_cnt`=0, `verified`=0, `verify_fail`=0, `send_v`=0.
  - Moves to VERIFICATION_IDLE when the global condition is false.
- VERIFICATION_IDLE:
  - The timer starts on entry.
  - On timer done, moves to SEND_VERIFY.
- SEND_VERIFY:
  - On entry, `send_v`=1 and `verify_cnt` increments. `verify_cnt` saturates at 7.
  - Stays in this state until `tx_v_ack`.
  - The edge that samples `tx_v_ack` clears `send_v` and moves to WAIT_FOR_RESPONSE.
- WAIT_FOR_RESPONSE:
  - The timer restarts on entry.
  - `rcv_r` moves to VERIFIED.
  - Otherwise, on timer done: moves to SEND_VERIFY if `verify_cnt < VERIFY_LIMIT`, else to VERIFY_FAIL.
  - If `rcv_r` and timer done occur in the same cycle, `rcv_r` wins.
- VERIFIED: `verified`=1. Terminal state; left only via the global condition.
- VERIFY_FAIL: `verify_fail`=1. Terminal state; left only via the global condition.
- `rcv_r` outside WAIT_FOR_RESPONSE is ignored.
- Respond handler, independent of the state machine:
  - `rcv_v` sets `send_r` when `p_enable & ~link_fail`.
  - `tx_r_ack` clears `send_r`.
  - If `rcv_v` and `tx_r_ack` arrive together, `send_r` stays 1 (new request pending).
  - `link_fail` or `~p_enable` clears `send_r`.
  - `disable_verify` does not suppress responses.

## Timing
- All outputs are registered.
- Reset values: state=INIT_VERIFICATION, and `send_v`, `send_r`, `verified`, `verify_fail`, `verify_cnt`, `preempt_active` are all 0.
- `reset` asserted mid-operation returns everything to reset values at the next edge. A timer in progress is discarded.
- Timer:
  - Loads `VERIFY_TIME-1` in the cycle the FSM enters a timing state.
  - Decrements each cycle and asserts done at count 0.
  - The state exits exactly `VERIFY_TIME` cycles after entry.
- Input-to-output latency: one cycle from any input pulse to the resulting output change.
- `preempt_active` rises one cycle after `verified` rises. When `disable_verify` is high, it rises one cycle after its inputs settle.
- Global-to-INIT transition: takes effect at the next edge. Outputs clear on that same edge.

## Structure
- Shared package `pkg_99_4_7` holds:
  - State encodings and the `VERIFY_CNT_W`=3 constant.
  - Default `VERIFY_TIME` values for simulation (16) and silicon (e.g. 10 ms / clock period).
- One sub-module, `mod_99_4_7_verify_timer`:
  - Inputs: `clk`, `reset`, `start`.
  - Output: `done`.
  - Parameter: `VERIFY_TIME`.
  - A `start` pulse reloads the counter, including while the timer is running.

## Test plan
- Happy path: `p_enable`=1, `VERIFY_TIME`=16.
  - `send_v` rises 17 cycles after reset release.
  - Ack, then `rcv_r` 5 cycles later: `verified`=1, `verify_cnt`=1, `preempt_active`=1 one cycle after `verified`.
- No response: three verify attempts, each 16-cycle window expires.
  - `verify_fail`=1 after the third timeout.
  - `verify_cnt`=3; `send_v` is never raised a fourth time.
- Same-cycle race: `rcv_r` coincides with timer done on the second attempt.
  - Result is VERIFIED with `verify_cnt`=2.
- Bypass: `disable_verify`=1.
  - State stays INIT_VERIFICATION; `send_v` never asserts; `preempt_active`=1.
  - `rcv_v` still raises `send_r` until `tx_r_ack`.
- Link drop: `link_fail` pulsed while in WAIT_FOR_RESPONSE.
  - Next edge: state=0, `verify_cnt`=0, `send_v`=0, `send_r`=0.
  - Verification restarts after `link_fail` falls.
- Reset mid-timer: `reset` asserted at cycle 8 of VERIFICATION_IDLE.
  - All outputs are 0 the next cycle.
  - After release, the full 16-cycle interval is re-timed from scratch.
